// File: rtl/wo_reg_write_arbiter.sv
// Write arbiter for NREQ masters onto a bank of NREG write-once registers with lock-on-bit-0.
// Define WO_REG_ARB_FIXED_PRIO_EN for fixed (lowest index wins) priority instead of round-robin.
module wo_reg_write_arbiter #(
    parameter int NREQ = 4,
    parameter int NREG = 4,
    parameter int DW   = 16,
    parameter int AW   = $clog2(NREG)
) (
    input  logic               Clk,
    input  logic               ip_resetn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    resp_valid,
    output logic               resp_err,
    output logic [NREG*DW-1:0] reg_data,
    output logic [NREG-1:0]    reg_locked,
    output logic [7:0]         err_count,
    output logic               busy
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                  state_q, state_d;
    logic [NREQ-1:0]         gnt_q, gnt_d;
    logic [NREQ-1:0]         resp_valid_q, resp_valid_d;
    logic                    resp_err_q, resp_err_d;
    logic                    busy_q, busy_d;
    logic [NREG-1:0][DW-1:0] regs_q, regs_d;
    logic [7:0]              err_count_q, err_count_d;
    logic [IW-1:0]           win_q, win_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [DW-1:0]           data_q, data_d;

    logic [IW-1:0]           pick;
    logic                    pick_vld;
    logic                    reject;

`ifdef WO_REG_ARB_FIXED_PRIO_EN
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                pick     = IW'(k);
                pick_vld = 1'b1;
            end
        end
    end
`else
    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] cand;

    // Scan from farthest to nearest so the requester right after last_q overrides the rest.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(last_q) + k) % NREQ);
            if (req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && pick_vld) begin
            last_d = pick;
        end
    end

    always_ff @(posedge Clk or negedge ip_resetn) begin
        if (!ip_resetn) begin
            last_q <= IW'(NREQ - 1);
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Out-of-range addresses are rejected just like writes to a locked register.
    assign reject = (int'(addr_q) >= NREG) || regs_q[addr_q][0];

    // NOTE: every _d gets its current value first, so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        regs_d       = regs_q;
        err_count_d  = err_count_q;
        win_d        = win_q;
        addr_d       = addr_q;
        data_d       = data_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d   = NREQ'(1) << pick;
                    win_d   = pick;
                    addr_d  = req_addr[pick*AW +: AW];
                    data_d  = req_data[pick*DW +: DW];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                gnt_d        = '0;
                resp_valid_d = NREQ'(1) << win_q;
                resp_err_d   = reject;
                if (reject) begin
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end else begin
                    regs_d[addr_q] = data_q;
                end
                state_d = RESP;
            end
            RESP: begin
                resp_valid_d = '0;
                resp_err_d   = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // NOTE: the register bank is reset here because a lock must clear only on ip_resetn.
    always_ff @(posedge Clk or negedge ip_resetn) begin
        if (!ip_resetn) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            resp_valid_q <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
            regs_q       <= '0;
            err_count_q  <= '0;
            win_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
            regs_q       <= regs_d;
            err_count_q  <= err_count_d;
            win_q        <= win_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
        end
    end

    always_comb begin
        reg_locked = '0;
        for (int i = 0; i < NREG; i++) begin
            reg_locked[i] = regs_q[i][0];
        end
    end

    assign gnt        = gnt_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign reg_data   = regs_q;
    assign err_count  = err_count_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_wo_reg_write_arbiter.sv
// Self-checking bench for wo_reg_write_arbiter: a reference model pushes expected
// responses on each grant; they are popped and compared when resp_valid appears.
module tb_wo_reg_write_arbiter;
    localparam int NREQ = 4;
    localparam int NREG = 4;
    localparam int DW   = 16;
    localparam int AW   = 2;

    logic               Clk = 1'b0;
    logic               ip_resetn = 1'b0;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    resp_valid;
    logic               resp_err;
    logic [NREG*DW-1:0] reg_data;
    logic [NREG-1:0]    reg_locked;
    logic [7:0]         err_count;
    logic               busy;

    wo_reg_write_arbiter #(.NREQ(NREQ), .NREG(NREG), .DW(DW), .AW(AW)) dut (
        .Clk        (Clk),
        .ip_resetn  (ip_resetn),
        .req        (req),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .gnt        (gnt),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .reg_data   (reg_data),
        .reg_locked (reg_locked),
        .err_count  (err_count),
        .busy       (busy)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int            idx;
        logic          err;
        int            addr;
        logic [DW-1:0] val;
        logic [7:0]    cnt;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model_regs [NREG];
    logic [7:0]    model_cnt;
    int            errors = 0;
    int            checks = 0;

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) model_regs[i] = '0;
        model_cnt = '0;
        sb.delete();
    endtask

    task automatic model_issue(input int r, input int a, input logic [DW-1:0] d);
        exp_t e;
        e.idx  = r;
        e.addr = a;
        e.err  = (a >= NREG) || model_regs[a][0];
        if (e.err) begin
            if (model_cnt != 8'hFF) model_cnt = model_cnt + 8'd1;
        end else begin
            model_regs[a] = d;
        end
        e.val = model_regs[a];
        e.cnt = model_cnt;
        sb.push_back(e);
    endtask

    task automatic set_req(input int r, input int a, input logic [DW-1:0] d);
        req[r]               = 1'b1;
        req_addr[r*AW +: AW] = AW'(a);
        req_data[r*DW +: DW] = d;
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        ip_resetn = 1'b0;
        req       = '0;
        repeat (2) @(negedge Clk);
        ip_resetn = 1'b1;
        model_reset();
    endtask

    // Waits (bounded) for any grant; returns the grant vector and negedges waited.
    task automatic wait_gnt(output logic [NREQ-1:0] g, output int waited);
        waited = 0;
        do begin
            @(negedge Clk);
            waited++;
        end while (gnt === '0 && waited < 10);
        g = gnt;
    endtask

    // Called at the grant negedge; the response must appear on the very next one.
    task automatic check_resp();
        int   n;
        exp_t e;
        n = 0;
        @(negedge Clk);
        while (resp_valid === '0 && n < 4) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL resp_latency: got %0d extra cycles (resp_valid=%b), want 0", n, resp_valid);
            return;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got resp_valid=%b with nothing expected", resp_valid);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (resp_valid !== (NREQ'(1) << e.idx)) begin
            errors++;
            $display("FAIL resp_valid: got %b want %b", resp_valid, NREQ'(1) << e.idx);
        end
        checks++;
        if (resp_err !== e.err) begin
            errors++;
            $display("FAIL resp_err: got %b want %b", resp_err, e.err);
        end
        checks++;
        if (reg_data[e.addr*DW +: DW] !== e.val) begin
            errors++;
            $display("FAIL reg_data[%0d]: got %h want %h", e.addr, reg_data[e.addr*DW +: DW], e.val);
        end
        checks++;
        if (reg_locked[e.addr] !== e.val[0]) begin
            errors++;
            $display("FAIL reg_locked[%0d]: got %b want %b", e.addr, reg_locked[e.addr], e.val[0]);
        end
        checks++;
        if (err_count !== e.cnt) begin
            errors++;
            $display("FAIL err_count: got %0d want %0d", err_count, e.cnt);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_resp: got %b want 1", busy);
        end
    endtask

    // Single-requester write from an idle FSM: grant must follow one cycle after drive.
    task automatic do_write(input int r, input int a, input logic [DW-1:0] d);
        logic [NREQ-1:0] g;
        int              w;
        @(negedge Clk);
        set_req(r, a, d);
        wait_gnt(g, w);
        req[r] = 1'b0;
        checks++;
        if (g !== (NREQ'(1) << r) || w != 1) begin
            errors++;
            $display("FAIL gnt: got %b after %0d cycles, want %b after 1", g, w, NREQ'(1) << r);
        end
        model_issue(r, a, d);
        check_resp();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge Clk);
        ip_resetn = 1'b1;
        model_reset();
        @(negedge Clk);
        checks++;
        if ({gnt, resp_valid, resp_err, busy} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got gnt=%b resp_valid=%b resp_err=%b busy=%b want all 0",
                     gnt, resp_valid, resp_err, busy);
        end
        checks++;
        if (reg_data !== '0 || reg_locked !== '0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_regs: got reg_data=%h locked=%b err_count=%0d want 0",
                     reg_data, reg_locked, err_count);
        end
    endtask

    task automatic test_lock();
        do_write(1, 2, 16'h1235);
    endtask

    task automatic test_reject();
        do_write(0, 2, 16'hFFFF);
        checks++;
        if (reg_data[2*DW +: DW] !== 16'h1235 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL reject_hold: got reg2=%h err_count=%0d want 1235 and 1",
                     reg_data[2*DW +: DW], err_count);
        end
    endtask

    task automatic test_rewrite();
        do_write(2, 0, 16'h00A0);
        do_write(2, 0, 16'h00B0);
        checks++;
        if (reg_data[0 +: DW] !== 16'h00B0 || reg_locked[0] !== 1'b0) begin
            errors++;
            $display("FAIL rewrite_final: got reg0=%h locked=%b want 00b0 and 0",
                     reg_data[0 +: DW], reg_locked[0]);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 256; i++) do_write(i % NREQ, 2, 16'(i));
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("FAIL err_saturate: got %0d want 255", err_count);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] g;
        int              w, exp_idx, last_cyc;
        apply_reset();
        @(negedge Clk);
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 16'(16'h0010 * (i + 1)));
        last_cyc = 0;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(g, w);
`ifdef WO_REG_ARB_FIXED_PRIO_EN
            exp_idx = 0;
`else
            exp_idx = k % NREQ;
`endif
            checks++;
            if (g !== (NREQ'(1) << exp_idx)) begin
                errors++;
                $display("FAIL arb_order[%0d]: got %b want %b", k, g, NREQ'(1) << exp_idx);
            end
            if (k > 0) begin
                checks++;
                if (cyc - last_cyc != 3) begin
                    errors++;
                    $display("FAIL arb_spacing[%0d]: got %0d cycles want 3", k, cyc - last_cyc);
                end
            end
            last_cyc = cyc;
            model_issue(exp_idx, 1, 16'(16'h0010 * (exp_idx + 1)));
            check_resp();
        end
        req = '0;
        repeat (3) @(negedge Clk);
        checks++;
        if (gnt !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL arb_quiet: got gnt=%b busy=%b want 0 and 0", gnt, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [NREQ-1:0] g;
        int              w;
        do_write(3, 3, 16'h0001);
        @(negedge Clk);
        set_req(0, 3, 16'h5556);
        wait_gnt(g, w);
        checks++;
        if (g !== 4'b0001) begin
            errors++;
            $display("FAIL mid_gnt: got %b want 0001", g);
        end
        ip_resetn = 1'b0;
        req       = '0;
        model_reset();
        repeat (2) @(negedge Clk);
        ip_resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (resp_valid !== '0 || gnt !== '0) begin
                errors++;
                $display("FAIL mid_no_resp[%0d]: got resp_valid=%b gnt=%b want 0", i, resp_valid, gnt);
            end
            @(negedge Clk);
        end
        checks++;
        if (reg_data !== '0 || reg_locked !== '0 || busy !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL mid_cleared: got reg_data=%h locked=%b busy=%b err_count=%0d want 0",
                     reg_data, reg_locked, busy, err_count);
        end
        do_write(1, 3, 16'h0003);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock();
        test_reject();
        test_rewrite();
        test_saturation();
        test_round_robin();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
